// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants, FSM state encoding and parity helper for the UART receive path.
// The UART_RX_MAJORITY_EN macro moves the sample decision from tick 7 to tick 8.
package uart_rx_ctrl_pkg;

    localparam int unsigned UART_DATA_WIDTH        = 8;
    localparam int unsigned UART_RX_FIFO_DEPTH     = 8;
    localparam int unsigned UART_RX_FIFO_PTR_WIDTH = 4;
    localparam int unsigned OVS                    = 16;

    localparam int unsigned TICK_W = $clog2(OVS);
    localparam int unsigned PTR_W  = UART_RX_FIFO_PTR_WIDTH;
    localparam int unsigned IDX_W  = UART_RX_FIFO_PTR_WIDTH - 1;

    localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(8);
`else
    localparam logic [TICK_W-1:0] SAMPLE_TICK = TICK_W'(7);
`endif

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } rx_state_e;

    // even = 1 -> bit that makes the total count of ones even
    function automatic logic expected_parity(input logic [UART_DATA_WIDTH-1:0] data,
                                             input logic even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_sync.sv
// Two-flop synchroniser for the serial input, plus a 3-tap majority vote when
// UART_RX_MAJORITY_EN is defined.
module uart_rx_ctrl_sync
    import uart_rx_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_async,
    input  logic              tick,
    input  logic [TICK_W-1:0] tick_idx,
    output logic              rx_s,
    output logic              sample
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_async};
        end
    end

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    localparam logic [TICK_W-1:0] VoteTickA = SAMPLE_TICK - TICK_W'(2);
    localparam logic [TICK_W-1:0] VoteTickB = SAMPLE_TICK - TICK_W'(1);

    logic vote_a_q, vote_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vote_a_q <= 1'b1;
            vote_b_q <= 1'b1;
        end else if (tick) begin
            if (tick_idx == VoteTickA) vote_a_q <= rx_s;
            if (tick_idx == VoteTickB) vote_b_q <= rx_s;
        end
    end

    // Third vote is the live value at the decision tick
    assign sample = (vote_a_q & vote_b_q) | (vote_a_q & rx_s) | (vote_b_q & rx_s);
`else
    logic unused_tick;
    assign unused_tick = ^{tick, tick_idx};
    assign sample      = rx_s;
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, 8-entry receive FIFO and sticky error flags.
// Define UART_RX_MAJORITY_EN for 3-tap majority sampling (ticks 6/7/8).
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
(
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       rx_sample_pulse,
    input  logic       UART_RX,
    input  logic       data_bits,
    input  logic       parity_en,
    input  logic       parity_odd0_even1,
    input  logic       rx_data_rd,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_full,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err
);

    rx_state_e                  state_q, state_d;
    logic [TICK_W-1:0]          tick_cnt_q, tick_cnt_d, tick_idx;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_WIDTH-1:0] shift_q, shift_d, data_byte;
    logic                       rx_s, bit_sample, decide;
    logic                       par_set, frm_set, ovr_set, push_req;

    logic [UART_DATA_WIDTH-1:0] fifo_mem_q [UART_RX_FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic                       fifo_empty, fifo_full, push, pop;
    logic                       parity_err_q, frame_err_q, overrun_err_q;

    uart_rx_ctrl_sync u_sync (
        .clk      (ACLK),
        .rst      (ARESET),
        .rx_async (UART_RX),
        .tick     (rx_sample_pulse),
        .tick_idx (tick_idx),
        .rx_s     (rx_s),
        .sample   (bit_sample)
    );

    // tick_cnt holds the index of the last tick; bit periods stay aligned to the start edge
    assign tick_idx  = tick_cnt_q + TICK_ONE;
    assign decide    = rx_sample_pulse && (tick_idx == SAMPLE_TICK);
    assign data_byte = {shift_q[7] & data_bits, shift_q[6:0]};

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_set    = 1'b0;
        frm_set    = 1'b0;
        push_req   = 1'b0;

        if (rx_sample_pulse) tick_cnt_d = tick_idx;

        unique case (state_q)
            StIdle: begin
                if (rx_sample_pulse && !rx_s) begin
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                end
            end
            StStart: begin
                if (decide) begin
                    state_d   = bit_sample ? StIdle : StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (decide) begin
                    shift_d[bit_cnt_q] = bit_sample;
                    if (bit_cnt_q == {2'b11, data_bits}) begin
                        state_d = parity_en ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (decide) begin
                    par_set = bit_sample != expected_parity(data_byte, parity_odd0_even1);
                    state_d = StStop;
                end
            end
            StStop: begin
                if (decide) begin
                    frm_set  = !bit_sample;
                    push_req = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Receive FIFO; a pop in the same cycle frees the slot a full-FIFO push needs
    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                        (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    assign pop        = rx_data_rd && !fifo_empty;
    assign push       = push_req && (!fifo_full || pop);
    assign ovr_set    = push_req && fifo_full && !pop;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) fifo_mem_q[wr_ptr_q[IDX_W-1:0]] <= data_byte;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            parity_err_q  <= par_set | (parity_err_q & ~err_clr);
            frame_err_q   <= frm_set | (frame_err_q & ~err_clr);
            overrun_err_q <= ovr_set | (overrun_err_q & ~err_clr);
        end
    end

    assign rx_data       = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q[IDX_W-1:0]];
    assign rx_data_valid = !fifo_empty;
    assign rx_full       = fifo_full;
    assign parity_err    = parity_err_q;
    assign frame_err     = frame_err_q;
    assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven bit by bit against a 1-in-4 sample tick.
module tb_uart_rx_ctrl;

    logic       ACLK;
    logic       ARESET;
    logic       rx_sample_pulse;
    logic       UART_RX;
    logic       data_bits;
    logic       parity_en;
    logic       parity_odd0_even1;
    logic       rx_data_rd;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_full;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl dut (
        .ACLK              (ACLK),
        .ARESET            (ARESET),
        .rx_sample_pulse   (rx_sample_pulse),
        .UART_RX           (UART_RX),
        .data_bits         (data_bits),
        .parity_en         (parity_en),
        .parity_odd0_even1 (parity_odd0_even1),
        .rx_data_rd        (rx_data_rd),
        .err_clr           (err_clr),
        .rx_data           (rx_data),
        .rx_data_valid     (rx_data_valid),
        .rx_full           (rx_full),
        .parity_err        (parity_err),
        .frame_err         (frame_err),
        .overrun_err       (overrun_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        rx_sample_pulse = 1'b0;
        forever begin
            repeat (3) @(negedge ACLK);
            rx_sample_pulse = 1'b1;
            @(negedge ACLK);
            rx_sample_pulse = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns on the falling edge right after the n-th tick
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge ACLK); while (!rx_sample_pulse);
        end
        @(negedge ACLK);
    endtask

    task automatic send_bit(input logic b);
        UART_RX = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_on,
                              input logic par_bit, input logic stop_ok);
        wait_ticks(1);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (par_on) send_bit(par_bit);
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            // Low across the sample window only, so the tail does not look like a start bit
            UART_RX = 1'b0;
            wait_ticks(9);
            UART_RX = 1'b1;
            wait_ticks(7);
        end
        UART_RX = 1'b1;
    endtask

    task automatic pop();
        rx_data_rd = 1'b1;
        @(negedge ACLK);
        rx_data_rd = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge ACLK);
        err_clr = 1'b0;
    endtask

    task automatic check_errs(input string tag, input logic [2:0] exp);
        check(tag, {5'd0, parity_err, frame_err, overrun_err}, {5'd0, exp});
    endtask

    initial begin
        ARESET            = 1'b1;
        UART_RX           = 1'b1;
        data_bits         = 1'b1;
        parity_en         = 1'b0;
        parity_odd0_even1 = 1'b0;
        rx_data_rd        = 1'b0;
        err_clr           = 1'b0;
        repeat (4) @(negedge ACLK);
        ARESET = 1'b0;

        check("rst_data", rx_data, 8'h00);
        check("rst_valid", {7'd0, rx_data_valid}, 8'h00);
        check("rst_full", {7'd0, rx_full}, 8'h00);
        check_errs("rst_errs", 3'b000);
        wait_ticks(2);

        // 8N1 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_valid", {7'd0, rx_data_valid}, 8'h01);
        check_errs("a5_errs", 3'b000);
        pop();
        check("a5_pop_valid", {7'd0, rx_data_valid}, 8'h00);

        // 7E1 0x35, good parity then bad parity
        data_bits         = 1'b0;
        parity_en         = 1'b1;
        parity_odd0_even1 = 1'b1;
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
        check("7e1_data", rx_data, 8'h35);
        check_errs("7e1_errs", 3'b000);
        pop();
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
        check("7e1_bad_data", rx_data, 8'h35);
        check_errs("7e1_bad_errs", 3'b100);
        pop();
        clear_errors();
        check_errs("7e1_clr", 3'b000);

        // 8O1 0x00 with a low stop bit
        data_bits         = 1'b1;
        parity_odd0_even1 = 1'b0;
        send_frame(8'h00, 8, 1'b1, 1'b1, 1'b0);
        check("8o1_valid", {7'd0, rx_data_valid}, 8'h01);
        check("8o1_data", rx_data, 8'h00);
        check_errs("8o1_errs", 3'b010);
        pop();
        clear_errors();

        // 6-tick glitch on an idle line
        parity_en = 1'b0;
        wait_ticks(1);
        UART_RX = 1'b0;
        wait_ticks(6);
        UART_RX = 1'b1;
        wait_ticks(24);
        check("glitch_valid", {7'd0, rx_data_valid}, 8'h00);
        check_errs("glitch_errs", 3'b000);

        // Nine bytes without popping: the ninth overruns
        for (int b = 1; b <= 8; b++) send_frame(8'(b), 8, 1'b0, 1'b0, 1'b1);
        check("fill_full", {7'd0, rx_full}, 8'h01);
        check_errs("fill_errs", 3'b000);
        send_frame(8'h09, 8, 1'b0, 1'b0, 1'b1);
        check("ovr_full", {7'd0, rx_full}, 8'h01);
        check_errs("ovr_errs", 3'b001);
        for (int b = 1; b <= 8; b++) begin
            check($sformatf("ovr_pop%0d", b), rx_data, 8'(b));
            pop();
        end
        check("ovr_empty", {7'd0, rx_data_valid}, 8'h00);
        clear_errors();
        check_errs("ovr_clr", 3'b000);

        // Populate state, then reset during data bit 3 of 0xC3
        parity_en         = 1'b1;
        parity_odd0_even1 = 1'b1;
        send_frame(8'h11, 8, 1'b1, 1'b1, 1'b1);
        check("pre_rst_valid", {7'd0, rx_data_valid}, 8'h01);
        check_errs("pre_rst_errs", 3'b100);
        parity_en = 1'b0;
        wait_ticks(1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        UART_RX = 1'b0;
        wait_ticks(8);
        ARESET  = 1'b1;
        UART_RX = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", {7'd0, rx_data_valid}, 8'h00);
        check("mid_rst_full", {7'd0, rx_full}, 8'h00);
        check_errs("mid_rst_errs", 3'b000);
        wait_ticks(20);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        check("post_rst_data", rx_data, 8'h5A);
        check("post_rst_valid", {7'd0, rx_data_valid}, 8'h01);
        check_errs("post_rst_errs", 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
